picorv32_mem_arbiter: RTL and testbench



---
 rtl/picorv32_pkg.sv | 12 +
 rtl/picorv32_mem_arbiter.sv | 113 +++++++++++
 tb/tb_picorv32_mem_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/picorv32_pkg.sv
// rtl/picorv32_pkg.sv - shared types and constants for the PicoRV32 memory arbiter
package picorv32_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_BUSY,
      ARB_GAP
   } arb_state_t;

   localparam int ARB_NPORTS = 2;

endpackage

// File: rtl/picorv32_mem_arbiter.sv
// rtl/picorv32_mem_arbiter.sv - two-port arbiter sharing one PicoRV32 native memory bus
// PICORV32_ARB_RR_EN selects round-robin ties; undefined gives fixed priority with s0 first.
module picorv32_mem_arbiter
   import picorv32_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        s0_mem_valid,
   input  logic        s0_mem_instr,
   input  logic [31:0] s0_mem_addr,
   input  logic [31:0] s0_mem_wdata,
   input  logic [3:0]  s0_mem_wstrb,
   output logic        s0_mem_ready,
   output logic [31:0] s0_mem_rdata,
   input  logic        s1_mem_valid,
   input  logic        s1_mem_instr,
   input  logic [31:0] s1_mem_addr,
   input  logic [31:0] s1_mem_wdata,
   input  logic [3:0]  s1_mem_wstrb,
   output logic        s1_mem_ready,
   output logic [31:0] s1_mem_rdata,
   output logic        m_mem_valid,
   output logic        m_mem_instr,
   output logic [31:0] m_mem_addr,
   output logic [31:0] m_mem_wdata,
   output logic [3:0]  m_mem_wstrb,
   input  logic        m_mem_ready,
   input  logic [31:0] m_mem_rdata,
   output logic [1:0]  grant,
   output logic        busy
);

   arb_state_t            state_q;
   logic [ARB_NPORTS-1:0] grant_q;
   logic [ARB_NPORTS-1:0] req;
   logic                  owner_valid;
   logic                  pref;

   // pref1 = 1 hands a simultaneous request to s1
   function automatic logic [ARB_NPORTS-1:0] pick(input logic [ARB_NPORTS-1:0] r,
                                                   input logic                  pref1);
      if (r == 2'b11) return pref1 ? 2'b10 : 2'b01;
      if (r[0])       return 2'b01;
      if (r[1])       return 2'b10;
      return 2'b00;
   endfunction

   assign req         = {s1_mem_valid, s0_mem_valid};
   assign owner_valid = |(grant_q & req);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= ARB_IDLE;
         grant_q <= '0;
      end else begin
         case (state_q)
            ARB_IDLE: if (|req) begin
               grant_q <= pick(req, pref);
               state_q <= ARB_BUSY;
            end
            // an owner dropping valid early is an abort: release without a ready
            ARB_BUSY: if (!owner_valid || m_mem_ready) begin
               grant_q <= '0;
               state_q <= ARB_GAP;
            end
            ARB_GAP:  state_q <= ARB_IDLE;
            default:  state_q <= ARB_IDLE;
         endcase
      end
   end

`ifdef PICORV32_ARB_RR_EN
   logic rr_q;

   always_ff @(posedge clk) begin
      if (!resetn)
         rr_q <= 1'b0;
      else if (state_q == ARB_BUSY && owner_valid && m_mem_ready)
         rr_q <= grant_q[0];
   end

   assign pref = rr_q;
`else
   assign pref = 1'b0;
`endif

   always_comb begin
      m_mem_instr = 1'b0;
      m_mem_addr  = '0;
      m_mem_wdata = '0;
      m_mem_wstrb = '0;
      if (grant_q[0]) begin
         m_mem_instr = s0_mem_instr;
         m_mem_addr  = s0_mem_addr;
         m_mem_wdata = s0_mem_wdata;
         m_mem_wstrb = s0_mem_wstrb;
      end else if (grant_q[1]) begin
         m_mem_instr = s1_mem_instr;
         m_mem_addr  = s1_mem_addr;
         m_mem_wdata = s1_mem_wdata;
         m_mem_wstrb = s1_mem_wstrb;
      end
   end

   assign m_mem_valid  = |grant_q;
   assign grant        = grant_q;
   assign busy         = (state_q != ARB_IDLE);
   assign s0_mem_ready = grant_q[0] & s0_mem_valid & m_mem_ready & resetn;
   assign s1_mem_ready = grant_q[1] & s1_mem_valid & m_mem_ready & resetn;
   assign s0_mem_rdata = m_mem_rdata;
   assign s1_mem_rdata = m_mem_rdata;

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// tb/tb_picorv32_mem_arbiter.sv - self-checking bench for picorv32_mem_arbiter
`timescale 1ns/1ps
module tb_picorv32_mem_arbiter;

`ifdef PICORV32_ARB_RR_EN
   localparam bit RR_MODE = 1'b1;
`else
   localparam bit RR_MODE = 1'b0;
`endif

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   logic        rv [2];
   logic        ri [2];
   logic [31:0] ra [2];
   logic [31:0] rw [2];
   logic [3:0]  rs [2];
   logic        m_mem_ready = 1'b0;
   logic [31:0] m_mem_rdata = '0;

   logic        s0_mem_ready, s1_mem_ready, m_mem_valid, m_mem_instr, busy;
   logic [31:0] s0_mem_rdata, s1_mem_rdata, m_mem_addr, m_mem_wdata;
   logic [3:0]  m_mem_wstrb;
   logic [1:0]  grant;

   picorv32_mem_arbiter dut (
      .clk(clk), .resetn(resetn),
      .s0_mem_valid(rv[0]), .s0_mem_instr(ri[0]), .s0_mem_addr(ra[0]),
      .s0_mem_wdata(rw[0]), .s0_mem_wstrb(rs[0]),
      .s0_mem_ready(s0_mem_ready), .s0_mem_rdata(s0_mem_rdata),
      .s1_mem_valid(rv[1]), .s1_mem_instr(ri[1]), .s1_mem_addr(ra[1]),
      .s1_mem_wdata(rw[1]), .s1_mem_wstrb(rs[1]),
      .s1_mem_ready(s1_mem_ready), .s1_mem_rdata(s1_mem_rdata),
      .m_mem_valid(m_mem_valid), .m_mem_instr(m_mem_instr), .m_mem_addr(m_mem_addr),
      .m_mem_wdata(m_mem_wdata), .m_mem_wstrb(m_mem_wstrb),
      .m_mem_ready(m_mem_ready), .m_mem_rdata(m_mem_rdata),
      .grant(grant), .busy(busy)
   );

   // reference model: who owns the bus, whether a gap is pending, tie preference
   int   owner = -1;
   bit   gap = 1'b0;
   bit   ptr = 1'b0;
   int   lat = 0;
   int   lat_cnt = 0;
   bit   snap_v [2];
   bit   snap_ready = 1'b0;
   bit   snap_rst = 1'b0;
   logic [1:0]  e_grant;
   logic        e_mv, e_busy, e_r0, e_r1;
   logic [68:0] e_fields;
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   int          cyc = 0;

   function automatic int pick_model(bit v0, bit v1);
      if (v0 && v1) return RR_MODE ? int'(ptr) : 0;
      return v0 ? 0 : 1;
   endfunction

   task automatic step();
      if (!snap_rst) begin
         owner = -1; gap = 1'b0; ptr = 1'b0;
      end else if (owner >= 0) begin
         if (!snap_v[owner]) begin
            owner = -1; gap = 1'b1;
         end else if (snap_ready) begin
            if (RR_MODE) ptr = (owner == 0);
            owner = -1; gap = 1'b1;
         end else begin
            lat_cnt++;
         end
      end else if (gap) begin
         gap = 1'b0;
      end else if (snap_v[0] || snap_v[1]) begin
         owner = pick_model(snap_v[0], snap_v[1]);
         lat_cnt = 0;
      end
      @(posedge clk); #1;
      cyc++;
      m_mem_ready = (owner >= 0) && (lat_cnt >= lat);
      m_mem_rdata = $urandom();
   endtask

   task automatic eval();
      #1;
      snap_v[0] = rv[0]; snap_v[1] = rv[1];
      snap_ready = m_mem_ready; snap_rst = resetn;
      e_grant  = (owner < 0) ? 2'b00 : ((owner == 0) ? 2'b01 : 2'b10);
      e_mv     = (owner >= 0);
      e_busy   = (owner >= 0) || gap;
      e_r0     = (owner == 0) && rv[0] && m_mem_ready && resetn;
      e_r1     = (owner == 1) && rv[1] && m_mem_ready && resetn;
      e_fields = (owner < 0) ? 69'd0 : {ri[owner], ra[owner], rw[owner], rs[owner]};
   endtask

   task automatic new_req(input int i);
      rv[i] = 1'b1;
      ri[i] = 1'($urandom_range(0, 1));
      ra[i] = $urandom();
      rw[i] = $urandom();
      rs[i] = 4'($urandom_range(0, 15));
   endtask

   task automatic settle(input int n);
      for (int k = 0; k < n; k++) begin
         step(); rv[0] = 1'b0; rv[1] = 1'b0; eval();
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      for (int i = 0; i < 2; i++) begin
         rv[i] = 1'b0; ri[i] = 1'b0; ra[i] = '0; rw[i] = '0; rs[i] = '0;
      end
      step(); eval(); step(); eval();
      n_cmp++;
      if ({grant, m_mem_valid, busy, s0_mem_ready, s1_mem_ready} !== 6'b0) begin
         n_bad++;
         $display("FAIL reset_ctrl got=%b want=000000", {grant, m_mem_valid, busy, s0_mem_ready, s1_mem_ready});
      end
      n_cmp++;
      if ({m_mem_instr, m_mem_addr, m_mem_wdata, m_mem_wstrb} !== 69'd0) begin
         n_bad++;
         $display("FAIL reset_fields got=%h want=0", {m_mem_instr, m_mem_addr, m_mem_wdata, m_mem_wstrb});
      end
      step(); resetn = 1'b1; eval();
      step(); eval();
   endtask

   task automatic test_single_read();
      int pulses = 0;
      int s1_pulses = 0;
      bit seen = 1'b0;
      logic [31:0] got = '0;
      step(); rv[0] = 1'b1; ri[0] = 1'b0; ra[0] = 32'h0000_1000; rw[0] = $urandom(); rs[0] = 4'h0; lat = 3; eval();
      n_cmp++;
      if (grant !== 2'b00) begin n_bad++; $display("FAIL sr_grant_cycleN got=%b want=00", grant); end
      step(); eval();
      n_cmp++;
      if ({grant, m_mem_valid, m_mem_addr, m_mem_wstrb} !== {2'b01, 1'b1, 32'h0000_1000, 4'h0}) begin
         n_bad++;
         $display("FAIL sr_request got=%b/%b/%h/%h want=01/1/00001000/0", grant, m_mem_valid, m_mem_addr, m_mem_wstrb);
      end
      for (int k = 0; k < 20 && !seen; k++) begin
         step();
         if (m_mem_ready) m_mem_rdata = 32'hCAFE_F00D;
         eval();
         if (s1_mem_ready) s1_pulses++;
         if (s0_mem_ready) begin pulses++; got = s0_mem_rdata; seen = 1'b1; end
      end
      n_cmp++;
      if (!seen) begin n_bad++; $display("FAIL sr_timeout got=no_ready want=ready within 20 cycles"); end
      n_cmp++;
      if (got !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL sr_rdata got=%h want=cafef00d", got); end
      step(); rv[0] = 1'b0; eval();
      if (s0_mem_ready) pulses++;
      if (s1_mem_ready) s1_pulses++;
      n_cmp++;
      if ({grant, m_mem_valid, busy} !== 4'b0001) begin
         n_bad++;
         $display("FAIL sr_gap got=%b want=0001", {grant, m_mem_valid, busy});
      end
      step(); eval();
      if (s0_mem_ready) pulses++;
      n_cmp++;
      if ({m_mem_valid, busy} !== 2'b00) begin n_bad++; $display("FAIL sr_idle got=%b want=00", {m_mem_valid, busy}); end
      n_cmp++;
      if (pulses != 1 || s1_pulses != 0) begin
         n_bad++;
         $display("FAIL sr_pulses got=s0:%0d s1:%0d want=s0:1 s1:0", pulses, s1_pulses);
      end
   endtask

   task automatic test_write_s1();
      bit seen = 1'b0;
      step(); rv[1] = 1'b1; ri[1] = 1'b0; ra[1] = $urandom(); rw[1] = 32'h1234_5678; rs[1] = 4'hF; lat = 1; eval();
      n_cmp++;
      if (grant !== 2'b00) begin n_bad++; $display("FAIL wr_grant_cycleN got=%b want=00", grant); end
      step(); eval();
      n_cmp++;
      if ({grant, m_mem_wstrb, m_mem_wdata, m_mem_addr} !== {2'b10, 4'hF, 32'h1234_5678, ra[1]}) begin
         n_bad++;
         $display("FAIL wr_request got=%b/%h/%h/%h want=10/f/12345678/%h", grant, m_mem_wstrb, m_mem_wdata, m_mem_addr, ra[1]);
      end
      for (int k = 0; k < 10 && !seen; k++) begin
         step(); eval();
         n_cmp++;
         if (s0_mem_ready !== 1'b0) begin n_bad++; $display("FAIL wr_s0_ready got=%b want=0", s0_mem_ready); end
         if (s1_mem_ready === 1'b1) seen = 1'b1;
      end
      n_cmp++;
      if (!seen) begin n_bad++; $display("FAIL wr_timeout got=no_ready want=s1 ready"); end
      settle(2);
   endtask

   task automatic test_contention();
      int done [2];
      bit pend [2];
      int dut_log [$];
      int exp_seq [8];
      logic [1:0] prev_g;
      int guard;
      done = '{0, 0}; pend = '{1'b0, 1'b0}; prev_g = 2'b00; guard = 0;
      for (int j = 0; j < 8; j++) exp_seq[j] = RR_MODE ? (j % 2) : (j / 4);
      step(); new_req(0); new_req(1); lat = 1; eval();
      while ((done[0] < 4 || done[1] < 4) && guard < 300) begin
         step(); guard++;
         for (int i = 0; i < 2; i++)
            if (pend[i]) begin
               pend[i] = 1'b0;
               if (done[i] < 4) new_req(i); else rv[i] = 1'b0;
            end
         if (owner < 0) lat = $urandom_range(0, 3);
         eval();
         n_cmp++;
         if ({grant, m_mem_valid, busy, s0_mem_ready, s1_mem_ready} !== {e_grant, e_mv, e_busy, e_r0, e_r1}) begin
            n_bad++;
            $display("FAIL cont_ctrl cyc=%0d got=%b want=%b", cyc,
                     {grant, m_mem_valid, busy, s0_mem_ready, s1_mem_ready}, {e_grant, e_mv, e_busy, e_r0, e_r1});
         end
         if (grant != 2'b00 && prev_g == 2'b00) dut_log.push_back(grant[1] ? 1 : 0);
         prev_g = grant;
         if (s0_mem_ready === 1'b1) begin done[0]++; pend[0] = 1'b1; end
         if (s1_mem_ready === 1'b1) begin done[1]++; pend[1] = 1'b1; end
      end
      n_cmp++;
      if (done[0] < 4 || done[1] < 4) begin
         n_bad++;
         $display("FAIL cont_timeout got=s0:%0d s1:%0d want=4/4", done[0], done[1]);
      end
      for (int j = 0; j < 8; j++) begin
         n_cmp++;
         if (j >= dut_log.size() || dut_log[j] != exp_seq[j]) begin
            n_bad++;
            $display("FAIL cont_order idx=%0d got=%0d want=%0d", j, (j < dut_log.size()) ? dut_log[j] : -1, exp_seq[j]);
         end
      end
      settle(3);
   endtask

   task automatic test_reset_mid_busy();
      bit seen = 1'b0;
      step(); new_req(0); lat = 1000; eval();
      step(); eval();
      n_cmp++;
      if (grant !== 2'b01) begin n_bad++; $display("FAIL rst_pre_grant got=%b want=01", grant); end
      step(); eval();
      step(); resetn = 1'b0; m_mem_ready = 1'b1; eval();
      n_cmp++;
      if ({s0_mem_ready, s1_mem_ready} !== 2'b00) begin
         n_bad++;
         $display("FAIL rst_no_ready got=%b want=00", {s0_mem_ready, s1_mem_ready});
      end
      step(); resetn = 1'b1; eval();
      n_cmp++;
      if ({grant, m_mem_valid, busy, s0_mem_ready} !== 5'b0) begin
         n_bad++;
         $display("FAIL rst_after got=%b want=00000", {grant, m_mem_valid, busy, s0_mem_ready});
      end
      step(); eval();
      n_cmp++;
      if ({grant, m_mem_valid, m_mem_addr} !== {2'b01, 1'b1, ra[0]}) begin
         n_bad++;
         $display("FAIL rst_rearb got=%b/%b/%h want=01/1/%h", grant, m_mem_valid, m_mem_addr, ra[0]);
      end
      lat = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
         step(); eval();
         if (s0_mem_ready === 1'b1) seen = 1'b1;
      end
      n_cmp++;
      if (!seen) begin n_bad++; $display("FAIL rst_complete got=no_ready want=s0 ready"); end
      settle(2);
   endtask

   task automatic test_abort();
      bit seen = 1'b0;
      int s0_pulses = 0;
      step(); resetn = 1'b0; eval();
      step(); resetn = 1'b1; eval();
      step(); new_req(0); lat = 1000; eval();
      step(); eval();
      step(); new_req(1); eval();
      step(); rv[0] = 1'b0; eval();
      if (s0_mem_ready) s0_pulses++;
      step(); eval();
      if (s0_mem_ready) s0_pulses++;
      n_cmp++;
      if ({grant, m_mem_valid, busy} !== 4'b0001) begin
         n_bad++;
         $display("FAIL ab_gap got=%b want=0001", {grant, m_mem_valid, busy});
      end
      step(); eval();
      n_cmp++;
      if (grant !== 2'b00) begin n_bad++; $display("FAIL ab_idle got=%b want=00", grant); end
      step(); eval();
      n_cmp++;
      if ({grant, m_mem_valid} !== 3'b101) begin n_bad++; $display("FAIL ab_s1_grant got=%b want=101", {grant, m_mem_valid}); end
      n_cmp++;
      if (s0_pulses != 0) begin n_bad++; $display("FAIL ab_s0_ready got=%0d want=0", s0_pulses); end
      lat = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
         step(); eval();
         if (s1_mem_ready === 1'b1) seen = 1'b1;
      end
      settle(2);
      // second abort by s0 followed by a tie: preference must be unchanged by the abort
      step(); new_req(0); lat = 1000; eval();
      step(); eval();
      step(); rv[0] = 1'b0; eval();
      step(); new_req(0); new_req(1); eval();
      step(); eval();
      step(); eval();
      n_cmp++;
      if (grant !== 2'b01) begin n_bad++; $display("FAIL ab_tie_after_abort got=%b want=01", grant); end
      lat = 0;
      for (int k = 0; k < 20 && (rv[0] || rv[1]); k++) begin
         step();
         if (s0_mem_ready === 1'b0 && s1_mem_ready === 1'b0) begin end
         eval();
         if (s0_mem_ready === 1'b1 || s1_mem_ready === 1'b1) begin
            step();
            if (owner == 0 || (snap_v[0] && !snap_v[1])) rv[0] = 1'b0;
            rv[owner < 0 ? 0 : owner] = rv[owner < 0 ? 0 : owner];
            eval();
         end
      end
      settle(4);
   endtask

   task automatic test_random();
      bit pend [2];
      pend = '{1'b0, 1'b0};
      for (int c = 0; c < 400; c++) begin
         step();
         for (int i = 0; i < 2; i++) begin
            if (pend[i]) begin
               pend[i] = 1'b0;
               if ($urandom_range(0, 1) == 1) new_req(i); else rv[i] = 1'b0;
            end else if (!rv[i]) begin
               if ($urandom_range(0, 2) == 0) new_req(i);
            end else if (owner == i && $urandom_range(0, 24) == 0) begin
               rv[i] = 1'b0;
            end
         end
         if (owner < 0) lat = $urandom_range(0, 4);
         eval();
         n_cmp++;
         if ({grant, m_mem_valid, busy, s0_mem_ready, s1_mem_ready} !== {e_grant, e_mv, e_busy, e_r0, e_r1}) begin
            n_bad++;
            $display("FAIL rnd_ctrl cyc=%0d got=%b want=%b", cyc,
                     {grant, m_mem_valid, busy, s0_mem_ready, s1_mem_ready}, {e_grant, e_mv, e_busy, e_r0, e_r1});
         end
         n_cmp++;
         if ({m_mem_instr, m_mem_addr, m_mem_wdata, m_mem_wstrb} !== e_fields) begin
            n_bad++;
            $display("FAIL rnd_fields cyc=%0d got=%h want=%h", cyc, {m_mem_instr, m_mem_addr, m_mem_wdata, m_mem_wstrb}, e_fields);
         end
         n_cmp++;
         if (s0_mem_rdata !== m_mem_rdata || s1_mem_rdata !== m_mem_rdata) begin
            n_bad++;
            $display("FAIL rnd_rdata cyc=%0d got=%h/%h want=%h", cyc, s0_mem_rdata, s1_mem_rdata, m_mem_rdata);
         end
         if (s0_mem_ready === 1'b1) pend[0] = 1'b1;
         if (s1_mem_ready === 1'b1) pend[1] = 1'b1;
      end
      settle(3);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=time limit want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_read();
      test_write_s1();
      test_contention();
      test_reset_mid_busy();
      test_abort();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
